// File: rtl/ecc_pkg.sv
// Shared types and Hamming(12,8) helpers for the ECC memory controller.
// Codeword bit [p-1] holds Hamming position p; parity sits at positions 1, 2, 4 and 8.
package ecc_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [3:0]        syndrome_t;

    typedef enum logic [1:0] {
        ECC_OK     = 2'd0,
        ECC_CORR   = 2'd1,
        ECC_UNCORR = 2'd2
    } ecc_status_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        CHECK   = 2'd2,
        WRBACK  = 2'd3
    } ctrl_state_e;

    // Each syndrome bit is the parity over the positions whose index has that bit set
    function automatic syndrome_t calc_syndrome(input code_t c);
        syndrome_t s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
        s[3] = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
        return s;
    endfunction

    // Data MSB sits at position 3, data LSB at position 12
    function automatic logic [DATA_W-1:0] extract_data(input code_t c);
        return {c[2], c[4], c[5], c[6], c[8], c[9], c[10], c[11]};
    endfunction

endpackage

// File: rtl/hamming12_check.sv
// Hamming(12,8) syndrome check and single-bit correction of a read codeword.
module hamming12_check
    import ecc_pkg::*;
(
    input  code_t             code,
    output syndrome_t         syndrome,
    output code_t             corrected,
    output logic [DATA_W-1:0] data,
    output ecc_status_e       status
);

    // Syndromes 13..15 point past the codeword, so they can only come from multi-bit errors
    always_comb begin
        syndrome  = calc_syndrome(code);
        corrected = code;
        status    = ECC_OK;
        if (syndrome == 4'd0) begin
            status = ECC_OK;
        end else if (syndrome <= 4'd12) begin
            corrected = code ^ (12'd1 << (syndrome - 4'd1));
            status    = ECC_CORR;
        end else begin
            status = ECC_UNCORR;
        end
        data = extract_data(corrected);
    end

endmodule

// File: rtl/hamming_encoder.sv
// Hamming(12,8) encoder: places the data byte and fills the four parity positions.
module hamming_encoder
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output code_t             code
);
    code_t     raw_s;
    syndrome_t par_s;

    // Syndrome of the data-only word equals the parity bits that make it zero
    always_comb begin
        raw_s = {data[0], data[1], data[2], data[3], 1'b0, data[4], data[5], data[6],
                 1'b0, data[7], 1'b0, 1'b0};
        par_s = calc_syndrome(raw_s);
        code  = raw_s;
        code[0] = par_s[0];
        code[1] = par_s[1];
        code[3] = par_s[2];
        code[7] = par_s[3];
    end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// ECC-protected SRAM sequencer: host read/write port plus a background scrubber
// sharing one single-port 12-bit RAM with 1-cycle read latency.
module ecc_mem_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int DEPTH          = 64,
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_wdata_i,
    output logic              rsp_valid_o,
    output logic [7:0]        rsp_rdata_o,
    output logic [1:0]        rsp_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [11:0]       mem_wdata_o,
    input  logic [11:0]       mem_rdata_i,
    input  logic              scrub_en_i,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              uncorr_o
);
    localparam int                TMR_W    = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    ctrl_state_e       state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] scrub_ptr_r;
    logic              is_scrub_r;
    code_t             corr_code_r;
    ecc_status_e       status_r;
    logic              rsp_valid_r;
    logic [7:0]        rsp_rdata_r;
    logic [1:0]        rsp_err_r;
    logic [TMR_W-1:0]  scrub_tmr_r;
    logic              scrub_pend_r;
    logic [CNT_W-1:0]  err_count_r;
    logic              uncorr_r;

    code_t       enc_code_s;
    code_t       chk_code_s;
    syndrome_t   chk_syn_s;
    logic [7:0]  chk_data_s;
    ecc_status_e chk_status_s;
    logic        scrub_expire_s;
    logic        scrub_pend_s;

    hamming_encoder u_enc (
        .data (req_wdata_i),
        .code (enc_code_s)
    );

    hamming12_check u_chk (
        .code      (mem_rdata_i),
        .syndrome  (chk_syn_s),
        .corrected (chk_code_s),
        .data      (chk_data_s),
        .status    (chk_status_s)
    );

    // An expiring timer counts as pending immediately so the scrub wins that same cycle
    assign scrub_expire_s = scrub_en_i & (scrub_tmr_r == TMR_LAST);
    assign scrub_pend_s   = scrub_pend_r | scrub_expire_s;
    assign req_ready_o    = rst_ni & (state_r == IDLE) & ~scrub_pend_s;

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign err_count_o = err_count_r;
    assign uncorr_o    = uncorr_r;

    // RAM strobe mux: scrub or host issue in IDLE, corrected write-back in WRBACK
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 12'h000;
        if (!rst_ni) begin
            mem_en_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (scrub_pend_s) begin
                        mem_en_o   = 1'b1;
                        mem_addr_o = scrub_ptr_r;
                    end else if (req_valid_i) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = req_we_i;
                        mem_addr_o  = req_addr_i;
                        mem_wdata_o = req_we_i ? enc_code_s : 12'h000;
                    end else begin
                        mem_en_o = 1'b0;
                    end
                end
                WRBACK: begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = addr_r;
                    mem_wdata_o = corr_code_r;
                end
                default: begin
                    mem_en_o = 1'b0;
                end
            endcase
        end
    end

    // Controller FSM, scrub timer/pointer, response and error bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            scrub_ptr_r  <= '0;
            is_scrub_r   <= 1'b0;
            corr_code_r  <= 12'h000;
            status_r     <= ECC_OK;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 8'h00;
            rsp_err_r    <= 2'b00;
            scrub_tmr_r  <= '0;
            scrub_pend_r <= 1'b0;
            err_count_r  <= '0;
            uncorr_r     <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            if (scrub_en_i) begin
                scrub_tmr_r <= scrub_expire_s ? '0 : scrub_tmr_r + TMR_W'(1);
            end else begin
                scrub_tmr_r <= scrub_tmr_r;
            end
            scrub_pend_r <= scrub_pend_s & ~(state_r == IDLE);
            case (state_r)
                IDLE: begin
                    if (scrub_pend_s) begin
                        is_scrub_r <= 1'b1;
                        addr_r     <= scrub_ptr_r;
                        state_r    <= RD_WAIT;
                    end else if (req_valid_i && !req_we_i) begin
                        is_scrub_r <= 1'b0;
                        addr_r     <= req_addr_i;
                        state_r    <= RD_WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    corr_code_r <= chk_code_s;
                    status_r    <= chk_status_s;
                    rsp_valid_r <= ~is_scrub_r;
                    if (!is_scrub_r) begin
                        rsp_rdata_r <= chk_data_s;
                        rsp_err_r   <= chk_status_s;
                    end
                    if (chk_syn_s > 4'd12) begin
                        uncorr_r <= 1'b1;
                    end
                    state_r <= CHECK;
                end
                CHECK: begin
                    if (is_scrub_r) begin
                        scrub_ptr_r <= (scrub_ptr_r == PTR_LAST) ? '0 : scrub_ptr_r + ADDR_W'(1);
                    end
                    state_r <= (status_r == ECC_CORR) ? WRBACK : IDLE;
                end
                WRBACK: begin
                    if (err_count_r != {CNT_W{1'b1}}) begin
                        err_count_r <= err_count_r + CNT_W'(1);
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed bench for ecc_mem_ctrl with a behavioural 1-cycle-latency RAM and backdoor loads.
module tb_ecc_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = 12'h000;
    logic        scrub_en;
    logic [1:0]  err_count;
    logic        uncorr;

    logic        bd_en = 1'b0;
    logic [5:0]  bd_addr = 6'd0;
    logic [11:0] bd_data = 12'h000;
    logic [11:0] ram [64] = '{default: 12'h000};
    int          wr_cnt = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ecc_mem_ctrl #(
        .ADDR_W(6), .DEPTH(64), .SCRUB_INTERVAL(8), .CNT_W(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .scrub_en_i(scrub_en), .err_count_o(err_count), .uncorr_o(uncorr)
    );

    // RAM model: backdoor load, DUT writes, registered reads
    always @(posedge clk) begin
        if (bd_en) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic backdoor(input logic [5:0] a, input logic [11:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        cyc();
        bd_en = 1'b0;
    endtask

    task automatic wait_scrub(output int n);
        n = 0;
        #1;
        while (!(mem_en && !mem_we) && n < 40) begin
            cyc();
            n++;
        end
        check("scrub_issue_seen", 32'(mem_en && !mem_we), 32'd1);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] exp_d, input logic [1:0] exp_e,
                           input bit exp_wb, input logic [11:0] exp_code);
        int wr0;
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        #1;
        check("rd_accept_en_we_rdy", {mem_en, mem_we, req_ready}, 3'b101);
        cyc();
        req_valid = 1'b0;
        #1;
        check("rd_wait_no_rsp", {rsp_valid, req_ready}, 2'b00);
        cyc();
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_rdata", rsp_rdata, exp_d);
        check("rsp_err", rsp_err, exp_e);
        cyc();
        if (exp_wb) begin
            check("wb_strobe", {mem_en, mem_we, rsp_valid}, 3'b110);
            check("wb_addr", mem_addr, a);
            check("wb_wdata", mem_wdata, exp_code);
            cyc();
        end
        check("rd_back_idle", {mem_en, req_ready, rsp_valid}, 3'b010);
        check("rd_write_count", wr_cnt - wr0, exp_wb ? 1 : 0);
    endtask

    initial begin
        int n;
        int wr0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 6'd0;
        req_wdata = 8'h00; scrub_en = 1'b0;
        cyc(); cyc();
        check("reset_outputs", {req_ready, rsp_valid, mem_en, mem_we, uncorr}, 5'b00000);
        check("reset_err_count", err_count, 2'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", req_ready, 1'b1);

        // Encoded write then clean read
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 8'h33;
        #1;
        check("wr_strobe", {req_ready, mem_en, mem_we}, 3'b111);
        check("wr_addr", mem_addr, 6'd5);
        check("wr_codeword", mem_wdata, 12'hC6A);
        cyc();
        req_valid = 1'b0;
        check("wr_stays_idle", req_ready, 1'b1);
        check("ram5_written", ram[5], 12'hC6A);
        do_read(6'd5, 8'h33, 2'b00, 1'b0, 12'h000);

        // Single-bit error: corrected, written back, counted
        backdoor(6'd5, 12'hC4A);
        do_read(6'd5, 8'h33, 2'b01, 1'b1, 12'hC6A);
        check("ram5_fixed", ram[5], 12'hC6A);
        check("err_count_1", err_count, 2'd1);

        // Double-bit error, syndrome 13: raw data, sticky flag, no write-back
        backdoor(6'd5, 12'h46B);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5;
        wr0 = wr_cnt;
        cyc();
        req_valid = 1'b0;
        cyc();
        check("uncorr_rsp", {rsp_valid, rsp_err, uncorr}, 4'b1101);
        check("uncorr_rdata", rsp_rdata, 8'h32);
        cyc();
        check("uncorr_no_wb", {mem_en, req_ready}, 2'b01);
        cyc(); cyc();
        check("uncorr_sticky", uncorr, 1'b1);
        check("uncorr_no_write", wr_cnt - wr0, 0);
        check("uncorr_count_same", err_count, 2'd1);

        // Scrub: first issue on the 8th enabled cycle, addr 0 corrected
        backdoor(6'd0, 12'hC4A);
        scrub_en = 1'b1;
        wait_scrub(n);
        check("scrub_first_delay", n, 7);
        check("scrub0_addr", mem_addr, 6'd0);
        check("scrub_blocks_host", req_ready, 1'b0);
        cyc();
        cyc();
        check("scrub_no_rsp", rsp_valid, 1'b0);
        cyc();
        check("scrub_wb_strobe", {mem_en, mem_we}, 2'b11);
        check("scrub_wb_addr", mem_addr, 6'd0);
        check("scrub_wb_data", mem_wdata, 12'hC6A);
        cyc();
        check("scrub_err_count", err_count, 2'd2);
        wait_scrub(n);
        check("scrub_interval", n, 4);
        check("scrub1_addr", mem_addr, 6'd1);
        for (int k = 2; k < 64; k++) begin
            cyc();
            wait_scrub(n);
            check("scrub_walk_addr", mem_addr, k);
        end
        cyc();
        wait_scrub(n);
        check("scrub_wrap_addr", mem_addr, 6'd0);
        check("scrub_wrap_count", err_count, 2'd2);

        // Host read arriving on the expiry cycle waits out a clean scrub
        for (int k = 0; k < 8; k++) cyc();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd0;
        #1;
        check("arb_scrub_first", {req_ready, mem_en, mem_we}, 3'b010);
        check("arb_scrub_addr", mem_addr, 6'd1);
        cyc();
        check("arb_wait1", req_ready, 1'b0);
        cyc();
        check("arb_wait2", req_ready, 1'b0);
        cyc();
        check("arb_host_accept", {req_ready, mem_en, mem_we}, 3'b110);
        check("arb_host_addr", mem_addr, 6'd0);
        cyc();
        req_valid = 1'b0;
        cyc();
        check("arb_rsp", {rsp_valid, rsp_err}, 3'b100);
        check("arb_rdata", rsp_rdata, 8'h33);
        scrub_en = 1'b0;
        cyc();

        // Saturating counter (CNT_W=2)
        backdoor(6'd5, 12'hC4A);
        do_read(6'd5, 8'h33, 2'b01, 1'b1, 12'hC6A);
        check("count_reaches_max", err_count, 2'd3);
        backdoor(6'd5, 12'hC4A);
        do_read(6'd5, 8'h33, 2'b01, 1'b1, 12'hC6A);
        check("count_saturates", err_count, 2'd3);

        // Reset during WRBACK drops the write-back
        backdoor(6'd5, 12'hC4A);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5;
        cyc();
        req_valid = 1'b0;
        cyc(); cyc();
        check("pre_reset_wb", {mem_en, mem_we}, 2'b11);
        wr0 = wr_cnt;
        rst_n = 1'b0;
        cyc();
        check("rst_ctrl_outs", {req_ready, rsp_valid, rsp_err, mem_en, mem_we, uncorr}, 7'd0);
        check("rst_data_outs", {rsp_rdata, mem_addr, mem_wdata}, 26'd0);
        check("rst_err_count", err_count, 2'd0);
        rst_n = 1'b1;
        #1;
        check("rst_idle_ready", {req_ready, mem_en}, 2'b10);
        cyc();
        check("rst_no_write", wr_cnt - wr0, 0);
        check("rst_ram_untouched", ram[5], 12'hC4A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecc_mem_ctrl.md
Name: ecc_mem_ctrl

Overview:
Sequencing controller for a Hamming(12,8)-protected single-port SRAM. It shares the memory between a host request port and a background scrubber. Host writes are encoded on the way in. Reads are checked and corrected on the way out, and any corrected word is written back. The block sits between the bus-side requester and a 12-bit-wide RAM macro with 1-cycle read latency.

Parameters:
ADDR_W, 6, memory address width
DEPTH, 64, number of words; scrub pointer wraps at DEPTH-1
SCRUB_INTERVAL, 256, cycles between scrub reads while scrub_en_i=1 (>=4)
CNT_W, 16, width of the saturating corrected-error counter

Ports:
clk_i  in  1  single clock, rising edge
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  1  host request valid
req_ready_o  out  1  host request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_W  host address
req_wdata_i  in  8  host write data
rsp_valid_o  out  1  one-cycle pulse with read data
rsp_rdata_o  out  8  corrected read data
rsp_err_o  out  2  00 clean, 01 corrected, 10 uncorrectable
mem_en_o  out  1  RAM access strobe
mem_we_o  out  1  RAM write enable
mem_addr_o  out  ADDR_W  RAM address
mem_wdata_o  out  12  RAM write codeword
mem_rdata_i  in  12  RAM read codeword, valid the cycle after a read strobe
scrub_en_i  in  1  enables the scrub timer
err_count_o  out  CNT_W  saturating count of corrected errors (host and scrub)
uncorr_o  out  1  sticky flag, set on any uncorrectable syndrome

Behaviour:
- Reset, synchronous, rst_ni=0 at a clock edge:
  - state=IDLE; all outputs 0; scrub pointer, scrub timer, scrub pending, err_count_o and uncorr_o cleared.
  - A reset mid-operation drops any in-flight read, response or write-back.
- FSM states: IDLE, RD_WAIT, CHECK, WRBACK.
- Arbitration in IDLE:
  - Scrub pending beats host; req_ready_o = (state==IDLE) & ~scrub_pending.
  - req_ready_o is combinational and never depends on req_valid_i.
- Host write:
  - Accepted in IDLE; in the same cycle mem_en_o=mem_we_o=1 and mem_wdata_o=encode(req_wdata_i).
  - State stays IDLE, giving back-to-back writes at 1 per cycle. No response is returned.
- Host read:
  - Accept cycle T: mem_en_o=1, mem_we_o=0, go to RD_WAIT.
  - T+1: RAM returns data, go to CHECK.
  - T+2 (CHECK): decode mem_rdata_i registered at T+1. rsp_valid_o=1, rsp_rdata_o=corrected data, rsp_err_o set.
  - Fixed read latency: accept to rsp_valid_o = 2 cycles.
- Decode:
  - syndrome 0 -> clean.
  - syndrome 1..12 -> flip codeword bit [syndrome-1], status corrected.
  - syndrome 13..15 -> uncorrectable; data is passed through uncorrected, uncorr_o is set, no write-back.
- From CHECK:
  - status corrected -> WRBACK: write the corrected 12-bit codeword to the same address, increment err_count_o (saturating at all-ones), then IDLE.
  - otherwise -> IDLE.
- Scrub:
  - The timer counts only while scrub_en_i=1. At SCRUB_INTERVAL-1 it sets scrub_pending and restarts at 0.
  - A further expiry while pending is absorbed; pending never exceeds 1.
  - Scrub read uses the same IDLE->RD_WAIT->CHECK(->WRBACK) path at the scrub pointer, but rsp_valid_o stays 0.
  - Pending clears when the scrub read issues. The pointer increments in CHECK and wraps DEPTH-1 -> 0.
- Simultaneous events:
  - Scrub expiry in the same cycle a host request is waiting in IDLE -> scrub goes first, and the host waits with req_ready_o=0.
  - The host cannot collide with a write-back, because req_ready_o=0 outside IDLE.
- scrub_en_i deasserted: the timer freezes (no clear), and an already pending scrub still executes.

Decomposition:
- Package ecc_pkg holds:
  - CODE_W=12 and DATA_W=8.
  - Typedef code_t logic[11:0] and typedef syndrome_t logic[3:0].
  - Enum ecc_status_e {ECC_OK, ECC_CORR, ECC_UNCORR}.
  - Enum ctrl_state_e {IDLE, RD_WAIT, CHECK, WRBACK}.
- Reuse the existing hamming_encoder as-is for encode.
- One new combinational sub-module, hamming12_check:
  - Input: codeword.
  - Outputs: syndrome, corrected codeword, data byte, ecc_status_e.
  - Range-checks the syndrome before flipping.

Test Plan:
- Write 0x33 @addr 5, then read @5 -> mem_wdata_o=0xC6A; rsp_valid_o 2 cycles after accept, rdata=0x33, err=00, no write-back.
- Backdoor RAM[5]=0xC4A (bit 5 flipped), read @5 -> rdata=0x33, err=01; WRBACK cycle writes 0xC6A to addr 5; err_count_o=1.
- Backdoor RAM[5]=0x46B (bits 0 and 11 flipped, syndrome 13), read -> err=10, uncorr_o=1 sticky, no mem write, err_count_o unchanged.
- SCRUB_INTERVAL=8, scrub_en_i=1, RAM[0]=0xC4A -> scrub read of addr 0 with no rsp_valid_o, write-back of 0xC6A, pointer advances to 1. After DEPTH scrubs the pointer wraps to 0.
- Host read held valid on the cycle scrub pending sets -> req_ready_o=0 for the scrub sequence (3 cycles clean, 4 with write-back), then host accepted; response data correct.
- Assert rst_ni=0 during WRBACK -> next cycle all outputs 0, err_count_o=0, state IDLE, and the RAM receives no write after reset.
